// File: rtl/pipelined_mult_if.sv
// Operand and result valid/ready bundle for pipelined_mult.
interface pipelined_mult_if #(
  parameter int NUM_LANES  = 4,
  parameter int IN_0_WIDTH = 8,
  parameter int IN_1_WIDTH = 8,
  parameter int OUT_WIDTH  = IN_0_WIDTH + IN_1_WIDTH
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_LANES*IN_0_WIDTH-1:0]   in_0;
  logic [NUM_LANES*IN_1_WIDTH-1:0]   in_1;
  logic                              in_0_signed;
  logic                              in_1_signed;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_LANES*OUT_WIDTH-1:0]    out;

  modport master (
    output in_valid, in_0, in_1,
    output in_0_signed, in_1_signed,
    output out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_0, in_1,
    input  in_0_signed, in_1_signed,
    input  out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipelined_mult.sv
// Multi-lane pipelined multiplier, per-operand signedness,
// valid/ready on both sides with collapsing bubbles.
module pipelined_mult #(
  parameter int NUM_LANES   = 4,
  parameter int IN_0_WIDTH  = 8,
  parameter int IN_1_WIDTH  = 8,
  parameter int OUT_WIDTH   = IN_0_WIDTH + IN_1_WIDTH,
  parameter int PIPE_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  pipelined_mult_if.slave  bus
);
  localparam int PW = IN_0_WIDTH + IN_1_WIDTH + 2;
  localparam int EW = (OUT_WIDTH > PW) ? OUT_WIDTH : PW;
  localparam int DW = NUM_LANES * OUT_WIDTH;

  logic [DW-1:0]          w_prod;
  logic [PIPE_STAGES-1:0] w_load;
  logic [PIPE_STAGES-1:0] r_v;
  logic [DW-1:0]          r_data [PIPE_STAGES];

  // Extending both operands to EW bits makes the low OUT_WIDTH
  // bits of the product exact in every sign mode.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [IN_0_WIDTH-1:0] w_a;
    logic [IN_1_WIDTH-1:0] w_b;
    logic                  w_sa;
    logic                  w_sb;
    logic [EW-1:0]         w_ax;
    logic [EW-1:0]         w_bx;

    assign w_a  = bus.in_0[l*IN_0_WIDTH +: IN_0_WIDTH];
    assign w_b  = bus.in_1[l*IN_1_WIDTH +: IN_1_WIDTH];
    assign w_sa = bus.in_0_signed & w_a[IN_0_WIDTH-1];
    assign w_sb = bus.in_1_signed & w_b[IN_1_WIDTH-1];
    assign w_ax = {{(EW-IN_0_WIDTH){w_sa}}, w_a};
    assign w_bx = {{(EW-IN_1_WIDTH){w_sb}}, w_b};
    assign w_prod[l*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'(w_ax * w_bx);
  end

  // Stage k can load unless it and everything after it is
  // full while the output is stalled.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_load
    assign w_load[k] =
      ~(&r_v[PIPE_STAGES-1:k]) | bus.out_ready;
  end

  assign bus.in_ready  = w_load[0] & ~reset;
  assign bus.out_valid = r_v[PIPE_STAGES-1];
  assign bus.out       = r_data[PIPE_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0]    <= bus.in_valid;
        r_data[0] <= w_prod;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k]    <= r_v[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_mult.sv
// Bench for pipelined_mult: 8x8->16 two-stage and
// 8x8->20 single-stage instances against a queue model.
module tb_pipelined_mult;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid;
  logic        s_sa;
  logic        s_sb;
  logic        s_ordy;
  logic [31:0] s_a;
  logic [31:0] s_b;

  pipelined_mult_if #(.NUM_LANES(4), .IN_0_WIDTH(8),
    .IN_1_WIDTH(8), .OUT_WIDTH(16)) ifa ();
  pipelined_mult_if #(.NUM_LANES(4), .IN_0_WIDTH(8),
    .IN_1_WIDTH(8), .OUT_WIDTH(20)) ifb ();

  assign ifa.in_valid    = s_valid;
  assign ifa.in_0        = s_a;
  assign ifa.in_1        = s_b;
  assign ifa.in_0_signed = s_sa;
  assign ifa.in_1_signed = s_sb;
  assign ifa.out_ready   = s_ordy;
  assign ifb.in_valid    = s_valid;
  assign ifb.in_0        = s_a;
  assign ifb.in_1        = s_b;
  assign ifb.in_0_signed = s_sa;
  assign ifb.in_1_signed = s_sb;
  assign ifb.out_ready   = s_ordy;

  pipelined_mult #(.NUM_LANES(4), .IN_0_WIDTH(8),
    .IN_1_WIDTH(8), .OUT_WIDTH(16), .PIPE_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  pipelined_mult #(.NUM_LANES(4), .IN_0_WIDTH(8),
    .IN_1_WIDTH(8), .OUT_WIDTH(20), .PIPE_STAGES(1)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    logic [79:0] d;
    int          acc;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  logic rst_q = 1'b1;

  // Each lane is the true integer product, reduced mod 2^ow.
  function automatic logic [79:0] model(
    logic [31:0] a, logic [31:0] b,
    logic sa, logic sb, int ow);
    logic [79:0] r;
    logic [7:0]  ea;
    logic [7:0]  eb;
    longint      x;
    longint      y;
    longint      p;
    longint      m;
    r = '0;
    m = (longint'(1) << ow) - 1;
    for (int l = 0; l < 4; l++) begin
      ea = a[l*8 +: 8];
      eb = b[l*8 +: 8];
      x = sa ? longint'($signed(ea)) : longint'({56'b0, ea});
      y = sb ? longint'($signed(eb)) : longint'({56'b0, eb});
      p = (x * y) & m;
      r = r | (80'(p) << (l * ow));
    end
    return r;
  endfunction

  task automatic check(string name, logic [79:0] act,
                       logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q = reset;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ifa.out_valid && ifa.out_ready && qa.size() > 0)
        void'(qa.pop_front());
      if (ifb.out_valid && ifb.out_ready && qb.size() > 0)
        void'(qb.pop_front());
      if (ifa.in_valid && ifa.in_ready)
        qa.push_back('{d: model(s_a, s_b, s_sa, s_sb, 16),
                       acc: cyc});
      if (ifb.in_valid && ifb.in_ready)
        qb.push_back('{d: model(s_a, s_b, s_sa, s_sb, 20),
                       acc: cyc});
    end
  end

  logic        stall_a = 1'b0;
  logic        stall_b = 1'b0;
  logic [63:0] hold_a;
  logic [79:0] hold_b;

  always @(negedge clk) begin
    logic ev;
    if (cyc > 0) begin
      ev = qa.size() > 0 && (cyc - qa[0].acc >= 1);
      check("a_valid", ifa.out_valid, ev);
      if (ev) check("a_data", ifa.out, qa[0].d);
      check("a_ready", ifa.in_ready,
            !reset && !(qa.size() == 2 && !s_ordy));
      if (rst_q) check("a_rst_out", ifa.out, 0);
      if (stall_a && !rst_q) check("a_hold", ifa.out, hold_a);
      stall_a = ifa.out_valid && !ifa.out_ready;
      hold_a  = ifa.out;

      ev = qb.size() > 0;
      check("b_valid", ifb.out_valid, ev);
      if (ev) check("b_data", ifb.out, qb[0].d);
      check("b_ready", ifb.in_ready,
            !reset && !(qb.size() == 1 && !s_ordy));
      if (rst_q) check("b_rst_out", ifb.out, 0);
      if (stall_b && !rst_q) check("b_hold", ifb.out, hold_b);
      stall_b = ifb.out_valid && !ifb.out_ready;
      hold_b  = ifb.out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    s_valid = 1'b0;
    s_ordy  = 1'b1;
    repeat (n) step();
  endtask

  task automatic directed(string n, logic [31:0] a,
    logic [31:0] b, logic sa, logic sb,
    logic [15:0] ea0, logic [15:0] ea3, logic [19:0] eb0);
    s_a = a; s_b = b; s_sa = sa; s_sb = sb;
    s_valid = 1'b1;
    s_ordy  = 1'b1;
    @(negedge clk);
    check({n, "_rdy"}, ifa.in_ready & ifb.in_ready, 1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check({n, "_a_lat"}, ifa.out_valid, 0);
    check({n, "_b_v"}, ifb.out_valid, 1);
    check({n, "_b0"}, ifb.out[19:0], eb0);
    step();
    @(negedge clk);
    check({n, "_a_v"}, ifa.out_valid, 1);
    check({n, "_a0"}, ifa.out[15:0], ea0);
    check({n, "_a3"}, ifa.out[63:48], ea3);
    idle(3);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] t;
    case ($urandom_range(0, 7))
      0: t = 8'h00;
      1: t = 8'h01;
      2: t = 8'h7F;
      3: t = 8'h80;
      4: t = 8'hFF;
      default: t = 8'($urandom);
    endcase
    return t;
  endfunction

  initial begin
    int sent;
    int c;
    s_valid = 1'b0; s_sa = 1'b0; s_sb = 1'b0;
    s_ordy = 1'b1; s_a = '0; s_b = '0;

    check("pin_ss", model(32'hFF, 32'h02, 1, 1, 16), 80'hFFFE);
    check("pin_uu", model(32'hFF, 32'hFF, 0, 0, 16), 80'hFE01);
    check("pin_su", model(32'h80, 32'hFF, 1, 0, 16), 80'h8080);
    check("pin_l3", model(32'h7F000000, 32'h80000000, 1, 1, 16),
          80'hC080_0000_0000_0000);
    check("pin_w20", model(32'hFF, 32'hFF, 1, 0, 20), 80'hFFF01);

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    idle(2);

    directed("ss", 32'h0000_00FF, 32'h0000_0002, 1, 1,
             16'hFFFE, 16'h0000, 20'hFFFFE);
    directed("uu", 32'h0000_00FF, 32'h0000_00FF, 0, 0,
             16'hFE01, 16'h0000, 20'h0FE01);
    directed("ss1", 32'h0000_00FF, 32'h0000_00FF, 1, 1,
             16'h0001, 16'h0000, 20'h00001);
    directed("su", 32'h0000_0080, 32'h0000_00FF, 1, 0,
             16'h8080, 16'h0000, 20'hF8080);
    directed("l3", 32'h7F00_0000, 32'h8000_0000, 1, 1,
             16'h0000, 16'hC080, 20'h00000);
    directed("su20", 32'h0000_00FF, 32'h0000_00FF, 1, 0,
             16'hFF01, 16'h0000, 20'hFFF01);

    sent = 0;
    c = 0;
    while (sent < 8 && c < 100) begin
      s_ordy  = !(c >= 3 && c <= 6);
      s_valid = 1'b1;
      s_a = $urandom; s_b = $urandom;
      s_sa = 1'($urandom); s_sb = 1'($urandom);
      @(negedge clk);
      if (c >= 3 && c <= 6) check("stall_rdy", ifa.in_ready, 0);
      if (ifa.in_ready) sent++;
      step();
      c++;
    end
    check("b2b_sent", 80'(sent), 80'd8);
    idle(6);

    s_ordy = 1'b0;
    s_valid = 1'b1;
    s_a = 32'h1234_5678; s_b = 32'h9ABC_DEF0;
    step();
    step();
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdy", ifa.in_ready, 0);
    step();
    reset = 1'b0;
    s_ordy = 1'b1;
    @(negedge clk);
    check("rst_a_v", ifa.out_valid, 0);
    check("rst_b_v", ifb.out_valid, 0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      s_valid = $urandom_range(0, 3) != 0;
      s_ordy  = $urandom_range(0, 3) != 0;
      s_sa = 1'($urandom); s_sb = 1'($urandom);
      for (int l = 0; l < 4; l++) begin
        s_a[l*8 +: 8] = pick8();
        s_b[l*8 +: 8] = pick8();
      end
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
